h_seg_monitor: RTL and testbench

Registered trace monitor sitting directly downstream of the five-state segment FSM (codes A=0, B=1, C=2, D=3, E=4). Each valid cycle it samples the FSM's 8-bit state and checks its legality, including the first sample and every transition. It measures B/C loop segments and detects entry into the E sink. Results appear as sticky flags, counters and a single `prop` bit for the property checker.

---
 rtl/h_seg_pkg.sv | 37 +++
 rtl/h_seg_trans_check.sv | 26 ++
 rtl/h_seg_monitor.sv | 103 ++++++++++
 tb/tb_h_seg_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/h_seg_pkg.sv
// Shared definitions for the segment-FSM trace monitor:
// upstream state codes, monitor states and the legal-transition table.
package h_seg_pkg;

    localparam logic [7:0] S_A = 8'd0;
    localparam logic [7:0] S_B = 8'd1;
    localparam logic [7:0] S_C = 8'd2;
    localparam logic [7:0] S_D = 8'd3;
    localparam logic [7:0] S_E = 8'd4;

    typedef enum logic [2:0] {
        M_IDLE = 3'd0,
        M_RUN  = 3'd1,
        M_LOOP = 3'd2,
        M_TRAP = 3'd3,
        M_ERR  = 3'd4
    } mon_state_e;

    // A predecessor outside A..E has no legal successor.
    function automatic logic legal_next(
        input logic [7:0] prev,
        input logic [7:0] cur
    );
        logic ok;
        ok = 1'b0;
        unique case (prev)
            S_A:     ok = (cur == S_A) || (cur == S_B);
            S_B:     ok = (cur == S_C) || (cur == S_D);
            S_C:     ok = (cur == S_B);
            S_D:     ok = (cur == S_E);
            S_E:     ok = (cur == S_E);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/h_seg_trans_check.sv
// Combinational legality check of one sampled code against its predecessor.
// An illegal code suppresses the transition check for its own pair.
module h_seg_trans_check
    import h_seg_pkg::*;
(
    input  logic [7:0] prev,
    input  logic       prev_valid,
    input  logic [7:0] cur,
    output logic       is_illegal_code,
    output logic       is_bad_trans
);

    assign is_illegal_code = (cur > S_E);

    always_comb begin
        is_bad_trans = 1'b0;
        if (!is_illegal_code) begin
            if (prev_valid) begin
                is_bad_trans = !legal_next(prev, cur);
            end else begin
                is_bad_trans = (cur != S_A);
            end
        end
    end

endmodule

// File: rtl/h_seg_monitor.sv
// Registered trace monitor for the five-state segment FSM: sticky error
// flags, B/C loop length statistics and E-sink detection.
module h_seg_monitor
    import h_seg_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int LOOP_LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       state_in,
    output logic [2:0]       mon_state,
    output logic [CNT_W-1:0] loop_len,
    output logic [CNT_W-1:0] max_loop,
    output logic             trap,
    output logic             illegal,
    output logic             bad_trans,
    output logic             loop_over,
    output logic             prop
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(LOOP_LIMIT);

    mon_state_e       mon_q, mon_d;
    logic [7:0]       prev_q;
    logic             prev_valid_q;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             trap_q, trap_d;
    logic             ill_q, ill_d;
    logic             bad_q, bad_d;
    logic             over_q, over_d;
    logic             prop_q;
    logic             is_ill, is_bad, is_bc;

    h_seg_trans_check u_check (
        .prev           (prev_q),
        .prev_valid     (prev_valid_q),
        .cur            (state_in),
        .is_illegal_code(is_ill),
        .is_bad_trans   (is_bad)
    );

    assign is_bc = (state_in == S_B) || (state_in == S_C);

    always_comb begin
        ill_d  = ill_q | is_ill;
        bad_d  = bad_q | is_bad;
        trap_d = trap_q | (state_in == S_E);
        len_d  = '0;
        if (is_bc) begin
            len_d = (len_q == CNT_MAX) ? len_q : len_q + CNT_W'(1);
        end
        max_d  = (len_d > max_q) ? len_d : max_q;
        over_d = over_q | (len_d == LIMIT);
        mon_d  = M_RUN;
        if (mon_q == M_ERR || ill_d || bad_d) begin
            mon_d = M_ERR;
        end else if (state_in == S_E) begin
            mon_d = M_TRAP;
        end else if (is_bc) begin
            mon_d = M_LOOP;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mon_q        <= M_IDLE;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            len_q        <= '0;
            max_q        <= '0;
            trap_q       <= 1'b0;
            ill_q        <= 1'b0;
            bad_q        <= 1'b0;
            over_q       <= 1'b0;
            prop_q       <= 1'b1;
        end else if (in_valid) begin
            mon_q        <= mon_d;
            prev_q       <= state_in;
            prev_valid_q <= 1'b1;
            len_q        <= len_d;
            max_q        <= max_d;
            trap_q       <= trap_d;
            ill_q        <= ill_d;
            bad_q        <= bad_d;
            over_q       <= over_d;
            prop_q       <= !(ill_d || bad_d);
        end
    end

    assign mon_state = mon_q;
    assign loop_len  = len_q;
    assign max_loop  = max_q;
    assign trap      = trap_q;
    assign illegal   = ill_q;
    assign bad_trans = bad_q;
    assign loop_over = over_q;
    assign prop      = prop_q;

endmodule

// File: tb/tb_h_seg_monitor.sv
// Bench for h_seg_monitor: directed traces with literal expectations plus
// random traces compared every cycle against a behavioural model.
module tb_h_seg_monitor;

    localparam int CW  = 8;
    localparam int LIM = 4;
    localparam int SAT = 255;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [7:0]    state_in;
    logic [2:0]    mon_state;
    logic [CW-1:0] loop_len;
    logic [CW-1:0] max_loop;
    logic          trap;
    logic          illegal;
    logic          bad_trans;
    logic          loop_over;
    logic          prop;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    h_seg_monitor #(.CNT_W(CW), .LOOP_LIMIT(LIM)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .state_in (state_in),
        .mon_state(mon_state),
        .loop_len (loop_len),
        .max_loop (max_loop),
        .trap     (trap),
        .illegal  (illegal),
        .bad_trans(bad_trans),
        .loop_over(loop_over),
        .prop     (prop)
    );

    always #5 clock = ~clock;

    // Allowed successors of each code, as a bitmask over A..E.
    int succ [5] = '{5'b00011, 5'b01100, 5'b00010, 5'b10000, 5'b10000};

    // Model state, described in terms of the trace history.
    bit m_first = 1'b1;
    int m_prev  = 0;
    bit m_ill   = 1'b0;
    bit m_bad   = 1'b0;
    bit m_trap  = 1'b0;
    bit m_over  = 1'b0;
    int m_len   = 0;
    int m_max   = 0;
    int m_state = 0;

    task automatic model_reset();
        m_first = 1'b1;
        m_prev  = 0;
        m_ill   = 1'b0;
        m_bad   = 1'b0;
        m_trap  = 1'b0;
        m_over  = 1'b0;
        m_len   = 0;
        m_max   = 0;
        m_state = 0;
    endtask

    task automatic model_sample(input int c);
        bit ill, bad;
        bit in_loop;
        ill = (c > 4);
        bad = 1'b0;
        if (!ill) begin
            if (m_first) bad = (c != 0);
            else if (m_prev > 4) bad = 1'b1;
            else bad = !succ[m_prev][c];
        end
        m_ill   = m_ill | ill;
        m_bad   = m_bad | bad;
        in_loop = (c == 1) || (c == 2);
        m_len   = in_loop ? ((m_len + 1 > SAT) ? SAT : m_len + 1) : 0;
        if (m_len > m_max) m_max = m_len;
        if (m_len == LIM) m_over = 1'b1;
        if (c == 4) m_trap = 1'b1;
        if (m_ill || m_bad) m_state = 4;
        else if (c == 4) m_state = 3;
        else if (in_loop) m_state = 2;
        else m_state = 1;
        m_prev  = c;
        m_first = 1'b0;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else if (in_valid) model_sample(int'(state_in));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("m.mon_state", int'(mon_state), m_state);
            chk("m.loop_len", int'(loop_len), m_len);
            chk("m.max_loop", int'(max_loop), m_max);
            chk("m.trap", int'(trap), int'(m_trap));
            chk("m.illegal", int'(illegal), int'(m_ill));
            chk("m.bad_trans", int'(bad_trans), int'(m_bad));
            chk("m.loop_over", int'(loop_over), int'(m_over));
            chk("m.prop", int'(prop), int'(!(m_ill || m_bad)));
        end
    end

    task automatic step(input bit v, input int code);
        in_valid = v;
        state_in = 8'(code);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".mon_state"}, int'(mon_state), 0);
        chk({tag, ".loop_len"}, int'(loop_len), 0);
        chk({tag, ".max_loop"}, int'(max_loop), 0);
        chk({tag, ".flags"},
            int'({trap, illegal, bad_trans, loop_over}), 0);
        chk({tag, ".prop"}, int'(prop), 1);
    endtask

    int seq_loop [7] = '{0, 1, 2, 1, 2, 1, 3};
    int exp_len  [7] = '{0, 1, 2, 3, 4, 5, 0};
    int exp_over [7] = '{0, 0, 0, 0, 1, 1, 1};
    int seq_trap [6] = '{0, 0, 1, 3, 4, 4};

    initial begin
        int w_prev;
        int c;
        in_valid = 1'b0;
        state_in = 8'd0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        started = 1'b1;
        chk_reset_vals("reset");

        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq_trap[i]);
            if (i == 3) chk("trap.before_e", int'(trap), 0);
            if (i == 4) chk("trap.on_e", int'(trap), 1);
        end
        chk("trap.mon_state", int'(mon_state), 3);
        chk("trap.prop", int'(prop), 1);
        chk("trap.max_loop", int'(max_loop), 1);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq_loop[i]);
            chk("loop.loop_len", int'(loop_len), exp_len[i]);
            chk("loop.loop_over", int'(loop_over), exp_over[i]);
        end
        chk("loop.max_loop", int'(max_loop), 5);
        chk("loop.mon_state", int'(mon_state), 1);

        do_reset();
        step(1'b1, 1);
        chk("first_b.bad_trans", int'(bad_trans), 1);
        chk("first_b.prop", int'(prop), 0);
        chk("first_b.mon_state", int'(mon_state), 4);

        do_reset();
        step(1'b1, 0);
        step(1'b1, 9);
        chk("ill.illegal", int'(illegal), 1);
        chk("ill.bad_trans", int'(bad_trans), 0);
        chk("ill.mon_state", int'(mon_state), 4);
        step(1'b1, 0);
        chk("ill.succ_bad", int'(bad_trans), 1);

        do_reset();
        step(1'b1, 0);
        step(1'b1, 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, int'($urandom_range(0, 255)));
            chk("gap.loop_len", int'(loop_len), 1);
            chk("gap.mon_state", int'(mon_state), 2);
        end
        step(1'b1, 2);
        chk("gap.resume_len", int'(loop_len), 2);
        chk("gap.bad_trans", int'(bad_trans), 0);

        do_reset();
        step(1'b1, 0);
        step(1'b1, 1);
        step(1'b1, 2);
        step(1'b1, 1);
        chk("mid.loop_len", int'(loop_len), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1'b1, 0);
        chk("mid.first_a_bad", int'(bad_trans), 0);
        chk("mid.first_a_state", int'(mon_state), 1);
        chk("mid.first_a_prop", int'(prop), 1);

        do_reset();
        step(1'b1, 0);
        for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? 1 : 2);
        chk("sat.loop_len", int'(loop_len), SAT);
        chk("sat.max_loop", int'(max_loop), SAT);
        step(1'b1, 200);
        chk("sat.ill_len", int'(loop_len), 0);
        chk("sat.ill_max", int'(max_loop), SAT);
        chk("sat.ill_flag", int'(illegal), 1);

        do_reset();
        w_prev = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 59) begin
                do_reset();
                w_prev = -1;
            end
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, int'($urandom_range(0, 255)));
            end else if ($urandom_range(0, 39) == 0) begin
                c = int'($urandom_range(0, 255));
                step(1'b1, c);
                w_prev = (c > 4) ? -1 : c;
            end else begin
                if (w_prev < 0) begin
                    c = 0;
                end else begin
                    c = int'($urandom_range(0, 4));
                    while (!succ[w_prev][c]) c = int'($urandom_range(0, 4));
                end
                step(1'b1, c);
                w_prev = c;
            end
        end

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
